// File: rtl/ttm4_sequencer.sv
// ttm4_sequencer: FETCH/EXEC/NEXT control sequencer for the TTM4 program ROM datapath.
// Latency: one instruction takes 3 cycles (FETCH, EXEC, NEXT) with RUN held high; HALT is terminal.
// Backpressure: RUN=0 parks the sequencer in FETCH; an instruction already started always completes.
//
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   RUN                 run enable, sampled only in FETCH
//   INST[7:0]           ROM word at current PA: [7:4] opcode, [3:0] immediate
//   CARRY               ALU carry, sampled at the end of EXEC for JNC
//   nPC_LD / nPC_OPEN   active-low PC load / PC increment strobes (NEXT cycle)
//   nJRD_ST..nORU_ST    active-low store strobes (EXEC cycle)
//   nJRD_OUT..nIRU_OUT  active-low LOADBUS drive enables (EXEC cycle)
//   STORE_DATA[3:0]     immediate of the current instruction, held until next fetch
//   HALTED, ILLEGAL     halt indication, sticky undefined-opcode flag
module ttm4_sequencer (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RUN,
  input  logic [7:0] INST,
  input  logic       CARRY,
  output logic       nPC_LD,
  output logic       nPC_OPEN,
  output logic       nJRD_ST,
  output logic       nJRU_ST,
  output logic       nORD_ST,
  output logic       nORU_ST,
  output logic       nJRD_OUT,
  output logic       nJRU_OUT,
  output logic       nIRD_OUT,
  output logic       nIRU_OUT,
  output logic [3:0] STORE_DATA,
  output logic       HALTED,
  output logic       ILLEGAL
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_NEXT  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  // Strobe vector bit positions (all active-low).
  localparam int B_PC_LD   = 9;
  localparam int B_PC_OPEN = 8;
  localparam int B_JRD_ST  = 7;
  localparam int B_JRU_ST  = 6;
  localparam int B_ORD_ST  = 5;
  localparam int B_ORU_ST  = 4;
  localparam int B_JRD_OUT = 3;
  localparam int B_JRU_OUT = 2;
  localparam int B_IRD_OUT = 1;
  localparam int B_IRU_OUT = 0;

  localparam logic [3:0] OP_JMP  = 4'h5;
  localparam logic [3:0] OP_JNC  = 4'h6;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t      state_q, state_d;
  logic [7:0]  ireg_q, ireg_d;
  logic [9:0]  strb_q, strb_d;
  logic        halted_q, halted_d;
  logic        illegal_q, illegal_d;

  // EXEC-cycle strobe pattern for an opcode; at most one bit low.
  function automatic logic [9:0] exec_strobes(input logic [3:0] op);
    logic [9:0] s;
    s = '1;
    case (op)
      4'h1:    s[B_JRD_ST]  = 1'b0;
      4'h2:    s[B_JRU_ST]  = 1'b0;
      4'h3:    s[B_ORD_ST]  = 1'b0;
      4'h4:    s[B_ORU_ST]  = 1'b0;
      4'h7:    s[B_IRD_OUT] = 1'b0;
      4'h8:    s[B_IRU_OUT] = 1'b0;
      4'h9:    s[B_JRD_OUT] = 1'b0;
      4'hA:    s[B_JRU_OUT] = 1'b0;
      default: s = '1;
    endcase
    return s;
  endfunction

  always_comb begin
    state_d   = state_q;
    ireg_d    = ireg_q;
    strb_d    = '1;   // strobes are one-cycle pulses, high unless set below
    halted_d  = halted_q;
    illegal_d = illegal_q;

    case (state_q)
      S_FETCH: begin
        if (RUN) begin
          // Decode from INST directly so the EXEC strobe is already a flop
          // output during the EXEC cycle.
          ireg_d  = INST;
          strb_d  = exec_strobes(INST[7:4]);
          state_d = S_EXEC;
          if (INST[7:4] >= 4'hB && INST[7:4] <= 4'hE) begin
            illegal_d = 1'b1;
          end
        end
      end
      S_EXEC: begin
        if (ireg_q[7:4] == OP_HALT) begin
          // PC must not advance on HALT, so NEXT is skipped.
          state_d  = S_HALT;
          halted_d = 1'b1;
        end else begin
          state_d = S_NEXT;
          if (ireg_q[7:4] == OP_JMP || (ireg_q[7:4] == OP_JNC && !CARRY)) begin
            strb_d[B_PC_LD] = 1'b0;
          end else begin
            strb_d[B_PC_OPEN] = 1'b0;
          end
        end
      end
      S_NEXT: begin
        state_d = S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_FETCH;
      ireg_q    <= 8'h00;
      strb_q    <= '1;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ireg_q    <= ireg_d;
      strb_q    <= strb_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
    end
  end

  // IREG only changes on a fetch, so its immediate nibble doubles as the
  // registered STORE_DATA that holds its value outside EXEC.
  assign STORE_DATA = ireg_q[3:0];
  assign HALTED     = halted_q;
  assign ILLEGAL    = illegal_q;

  assign nPC_LD   = strb_q[B_PC_LD];
  assign nPC_OPEN = strb_q[B_PC_OPEN];
  assign nJRD_ST  = strb_q[B_JRD_ST];
  assign nJRU_ST  = strb_q[B_JRU_ST];
  assign nORD_ST  = strb_q[B_ORD_ST];
  assign nORU_ST  = strb_q[B_ORU_ST];
  assign nJRD_OUT = strb_q[B_JRD_OUT];
  assign nJRU_OUT = strb_q[B_JRU_OUT];
  assign nIRD_OUT = strb_q[B_IRD_OUT];
  assign nIRU_OUT = strb_q[B_IRU_OUT];

endmodule

// File: tb/tb_ttm4_sequencer.sv
// Testbench for ttm4_sequencer: vector table with a scoreboard queue plus hand-written corner sequences.
// Latency: checks EXEC, NEXT and return-to-FETCH cycles of every instruction.
// Backpressure: RUN low / HALT / reset-mid-instruction sequences.
module tb_ttm4_sequencer;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       RUN = 1'b0;
  logic [7:0] INST = 8'h00;
  logic       CARRY = 1'b0;
  logic       nPC_LD, nPC_OPEN, nJRD_ST, nJRU_ST, nORD_ST, nORU_ST;
  logic       nJRD_OUT, nJRU_OUT, nIRD_OUT, nIRU_OUT;
  logic [3:0] STORE_DATA;
  logic       HALTED, ILLEGAL;

  ttm4_sequencer dut (
    .CLK(CLK), .RST(RST), .RUN(RUN), .INST(INST), .CARRY(CARRY),
    .nPC_LD(nPC_LD), .nPC_OPEN(nPC_OPEN),
    .nJRD_ST(nJRD_ST), .nJRU_ST(nJRU_ST), .nORD_ST(nORD_ST), .nORU_ST(nORU_ST),
    .nJRD_OUT(nJRD_OUT), .nJRU_OUT(nJRU_OUT), .nIRD_OUT(nIRD_OUT), .nIRU_OUT(nIRU_OUT),
    .STORE_DATA(STORE_DATA), .HALTED(HALTED), .ILLEGAL(ILLEGAL)
  );

  always #5 CLK = ~CLK;

  // {nPC_LD,nPC_OPEN,nJRD_ST,nJRU_ST,nORD_ST,nORU_ST,nJRD_OUT,nJRU_OUT,nIRD_OUT,nIRU_OUT}
  logic [9:0] vec;
  assign vec = {nPC_LD, nPC_OPEN, nJRD_ST, nJRU_ST, nORD_ST, nORU_ST,
                nJRD_OUT, nJRU_OUT, nIRD_OUT, nIRU_OUT};

  localparam logic [9:0] ALL_HI = 10'h3FF;
  localparam logic [9:0] V_LD   = 10'h1FF;
  localparam logic [9:0] V_OPEN = 10'h2FF;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Mutual-exclusion monitor on every cycle while enabled.
  logic mon_en = 1'b0;
  always @(negedge CLK) begin
    if (mon_en) begin
      checks++;
      if ($countones(~vec) > 1) begin
        errors++;
        $display("FAIL onehot: strobes 0x%0h have more than one low at %0t", vec, $time);
      end
    end
  end

  typedef struct {
    logic [7:0] inst;
    logic       carry;
    logic [9:0] exec_v;
    logic [9:0] next_v;
    logic       ill;
  } vec_t;

  typedef struct {
    logic [9:0] exec_v;
    logic [9:0] next_v;
    logic [3:0] sd;
    logic       ill;
  } exp_t;

  exp_t exp_q[$];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    RUN = 1'b0;
    tick();
    tick();
    RST = 1'b0;
  endtask

  // Drives one instruction through FETCH->EXEC->NEXT->FETCH; CARRY is held
  // inverted outside EXEC so only the EXEC-cycle value can decide JNC.
  task automatic run_instr(input vec_t v);
    exp_t e;
    exp_q.push_back('{v.exec_v, v.next_v, v.inst[3:0], v.ill});
    RUN = 1'b1;
    INST = v.inst;
    CARRY = ~v.carry;
    tick();                           // now in EXEC
    e = exp_q.pop_front();
    check($sformatf("exec_vec %02h", v.inst), {22'd0, vec}, {22'd0, e.exec_v});
    check($sformatf("exec_sd %02h", v.inst), {28'd0, STORE_DATA}, {28'd0, e.sd});
    check($sformatf("exec_ill %02h", v.inst), {31'd0, ILLEGAL}, {31'd0, e.ill});
    CARRY = v.carry;
    INST = 8'hEE;                     // ROM bus changes must not matter now
    tick();                           // now in NEXT
    CARRY = ~v.carry;
    check($sformatf("next_vec %02h", v.inst), {22'd0, vec}, {22'd0, e.next_v});
    check($sformatf("next_sd %02h", v.inst), {28'd0, STORE_DATA}, {28'd0, e.sd});
    RUN = 1'b0;
    tick();                           // back in FETCH
    check($sformatf("fetch_vec %02h", v.inst), {22'd0, vec}, {22'd0, ALL_HI});
  endtask

  vec_t tbl[$];

  initial begin
    tbl = '{
      '{8'h3A, 1'b0, 10'h3DF, V_OPEN, 1'b0},
      '{8'h00, 1'b0, ALL_HI,  V_OPEN, 1'b0},
      '{8'h15, 1'b0, 10'h37F, V_OPEN, 1'b0},
      '{8'h27, 1'b1, 10'h3BF, V_OPEN, 1'b0},
      '{8'h41, 1'b0, 10'h3EF, V_OPEN, 1'b0},
      '{8'h70, 1'b0, 10'h3FD, V_OPEN, 1'b0},
      '{8'h8F, 1'b0, 10'h3FE, V_OPEN, 1'b0},
      '{8'h93, 1'b0, 10'h3F7, V_OPEN, 1'b0},
      '{8'hAC, 1'b0, 10'h3FB, V_OPEN, 1'b0},
      '{8'h56, 1'b1, ALL_HI,  V_LD,   1'b0},
      '{8'h62, 1'b0, ALL_HI,  V_LD,   1'b0},
      '{8'h69, 1'b1, ALL_HI,  V_OPEN, 1'b0},
      '{8'hC5, 1'b0, ALL_HI,  V_OPEN, 1'b1},
      '{8'hB0, 1'b0, ALL_HI,  V_OPEN, 1'b1},
      '{8'hD9, 1'b1, ALL_HI,  V_OPEN, 1'b1},
      '{8'hE4, 1'b0, ALL_HI,  V_OPEN, 1'b1},
      '{8'h1B, 1'b0, 10'h37F, V_OPEN, 1'b1}
    };

    do_reset();
    mon_en = 1'b1;

    // Reset state.
    check("rst_vec", {22'd0, vec}, {22'd0, ALL_HI});
    check("rst_sd", {28'd0, STORE_DATA}, 32'd0);
    check("rst_halted", {31'd0, HALTED}, 32'd0);
    check("rst_ill", {31'd0, ILLEGAL}, 32'd0);

    // RUN low parks in FETCH.
    for (int i = 0; i < 5; i++) begin
      tick();
      check("runlow_vec", {22'd0, vec}, {22'd0, ALL_HI});
    end

    // Main opcode table.
    foreach (tbl[i]) run_instr(tbl[i]);

    // ILLEGAL stays set across 20 NOPs.
    for (int i = 0; i < 20; i++) begin
      run_instr('{8'h00, 1'b0, ALL_HI, V_OPEN, 1'b1});
    end

    // RUN dropping during EXEC does not abort the instruction.
    do_reset();
    RUN = 1'b1; INST = 8'h41;
    tick();
    RUN = 1'b0;
    check("runabort_exec", {22'd0, vec}, {22'd0, 10'h3EF});
    tick();
    check("runabort_next", {22'd0, vec}, {22'd0, V_OPEN});
    tick();
    tick();
    check("runabort_parked", {22'd0, vec}, {22'd0, ALL_HI});

    // HALT: no PC strobe, RUN ignored, only RST leaves.
    do_reset();
    RUN = 1'b1; INST = 8'hF0;
    tick();
    check("halt_exec_vec", {22'd0, vec}, {22'd0, ALL_HI});
    INST = 8'h3A;
    tick();
    check("halt_halted", {31'd0, HALTED}, 32'd1);
    check("halt_vec", {22'd0, vec}, {22'd0, ALL_HI});
    for (int i = 0; i < 10; i++) begin
      RUN = ~RUN;
      tick();
      check("halt_hold_vec", {22'd0, vec}, {22'd0, ALL_HI});
      check("halt_hold_h", {31'd0, HALTED}, 32'd1);
      check("halt_hold_sd", {28'd0, STORE_DATA}, 32'd0);
    end
    do_reset();
    check("halt_rst_h", {31'd0, HALTED}, 32'd0);
    run_instr('{8'h3A, 1'b0, 10'h3DF, V_OPEN, 1'b0});

    // RST on the fetch edge of 0x15: no store strobe ever appears.
    RUN = 1'b1; INST = 8'h15; RST = 1'b1;
    tick();
    check("rstfetch_vec", {22'd0, vec}, {22'd0, ALL_HI});
    check("rstfetch_sd", {28'd0, STORE_DATA}, 32'd0);
    RUN = 1'b0; RST = 1'b0;
    tick();
    check("rstfetch_vec2", {22'd0, vec}, {22'd0, ALL_HI});

    // RST mid-EXEC of an illegal-free store: pending nPC_OPEN is suppressed.
    RUN = 1'b1; INST = 8'h15;
    tick();
    check("rstexec_exec", {22'd0, vec}, {22'd0, 10'h37F});
    RST = 1'b1; RUN = 1'b0;
    tick();
    check("rstexec_vec", {22'd0, vec}, {22'd0, ALL_HI});
    check("rstexec_sd", {28'd0, STORE_DATA}, 32'd0);
    RST = 1'b0;
    tick();
    check("rstexec_vec2", {22'd0, vec}, {22'd0, ALL_HI});

    // RST mid-NEXT: illegal flag cleared too.
    RUN = 1'b1; INST = 8'hC7;
    tick();
    tick();
    RST = 1'b1; RUN = 1'b0;
    tick();
    check("rstnext_vec", {22'd0, vec}, {22'd0, ALL_HI});
    check("rstnext_ill", {31'd0, ILLEGAL}, 32'd0);
    RST = 1'b0;

    // Random stream, excluding HALT; monitor checks exclusivity every cycle.
    for (int i = 0; i < 300; i++) begin
      RUN   = ($urandom_range(0, 3) != 0);
      INST  = {4'($urandom_range(0, 14)), 4'($urandom_range(0, 15))};
      CARRY = 1'($urandom_range(0, 1));
      tick();
    end
    check("random_halted", {31'd0, HALTED}, 32'd0);

    mon_en = 1'b0;
    check("queue_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
